// File: rtl/pe_sequencer.sv
// Job sequencer for one PE datapath: per pixel it walks count, read, popcount,
// accumulate and binarize, then hands the pixel downstream with valid/ready.
//
// state | meaning
// IDLE  | waiting for start
// CNT   | address generation, isCount high until cntDone
// READ  | memory read, isRead high until readDone & readyToPick
// PCNT  | popcount, continuePcnt high until pcntDone
// ACC   | accumulate, continueAcc/addPcnts high until accDone
// BIN   | binarize, binarizeStart high until finishAll
// OUT   | out_valid held until out_ready
// DONE  | one-cycle done pulse
// ERR   | phase watchdog expired, left only through rst
module pe_sequencer #(
  parameter int synopseFold    = 18,
  parameter int input_address  = 12,
  parameter int weight_address = 12,
  parameter int num_pixels     = 4,
  parameter int pix_width      = 8,
  parameter int timeout_cycles = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [input_address-1:0]  in_base,
  input  logic [weight_address-1:0] w_base,
  input  logic                      cntDone,
  input  logic                      readDone,
  input  logic                      readyToPick,
  input  logic                      pcntDone,
  input  logic                      accDone,
  input  logic                      finishAll,
  input  logic                      out_ready,
  output logic                      isCount,
  output logic                      isRead,
  output logic                      continuePcnt,
  output logic                      continueAcc,
  output logic                      addPcnts,
  output logic                      binarizeStart,
  output logic [input_address-1:0]  firstInputAddress,
  output logic [weight_address-1:0] firstWeightAddress,
  output logic                      out_valid,
  output logic [pix_width-1:0]      pix_index,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int WD_W = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles);
  localparam logic [WD_W-1:0]           WD_LAST  = WD_W'(timeout_cycles - 1);
  localparam logic [pix_width-1:0]      PIX_LAST = pix_width'(num_pixels - 1);
  localparam logic [weight_address-1:0] W_STEP   = weight_address'(synopseFold);

  typedef enum logic [3:0] {
    S_IDLE, S_CNT, S_READ, S_PCNT, S_ACC, S_BIN, S_OUT, S_DONE, S_ERR
  } state_e;

  state_e                    state_q, state_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic [pix_width-1:0]      pix_q, pix_d;
  logic [input_address-1:0]  ia_q, ia_d;
  logic [weight_address-1:0] wa_q, wa_d;

  logic is_count_q, is_read_q, cont_pcnt_q, cont_acc_q, bin_start_q;
  logic out_valid_q, busy_q, done_q, error_q;

  logic wd_expired;
  logic watched_d;

  assign wd_expired = (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    ia_d    = ia_q;
    wa_d    = wa_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CNT;
          ia_d    = in_base;
          wa_d    = w_base;
          pix_d   = '0;
        end
      end
      S_CNT: begin
        if (cntDone)         state_d = S_READ;
        else if (wd_expired) state_d = S_ERR;
      end
      S_READ: begin
        if (readDone && readyToPick) state_d = S_PCNT;
        else if (wd_expired)         state_d = S_ERR;
      end
      S_PCNT: begin
        if (pcntDone)        state_d = S_ACC;
        else if (wd_expired) state_d = S_ERR;
      end
      S_ACC: begin
        if (accDone)         state_d = S_BIN;
        else if (wd_expired) state_d = S_ERR;
      end
      S_BIN: begin
        if (finishAll)       state_d = S_OUT;
        else if (wd_expired) state_d = S_ERR;
      end
      S_OUT: begin
        if (out_ready) begin
          if (pix_q == PIX_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CNT;
            pix_d   = pix_q + 1'b1;
            wa_d    = wa_q + W_STEP;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    // abort beats every transition above, including an accepted pixel
    if (abort && state_q != S_ERR) begin
      state_d = S_IDLE;
      pix_d   = '0;
    end
  end

  // watchdog runs only while waiting on a datapath flag; OUT may stall forever
  assign watched_d = (state_d == S_CNT) || (state_d == S_READ) || (state_d == S_PCNT) ||
                     (state_d == S_ACC) || (state_d == S_BIN);
  assign wd_d      = (watched_d && state_d == state_q) ? wd_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      pix_q       <= '0;
      ia_q        <= '0;
      wa_q        <= '0;
      is_count_q  <= 1'b0;
      is_read_q   <= 1'b0;
      cont_pcnt_q <= 1'b0;
      cont_acc_q  <= 1'b0;
      bin_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      pix_q       <= pix_d;
      ia_q        <= ia_d;
      wa_q        <= wa_d;
      is_count_q  <= (state_d == S_CNT);
      is_read_q   <= (state_d == S_READ);
      cont_pcnt_q <= (state_d == S_PCNT);
      cont_acc_q  <= (state_d == S_ACC);
      bin_start_q <= (state_d == S_BIN);
      out_valid_q <= (state_d == S_OUT);
      busy_q      <= (state_d != S_IDLE) && (state_d != S_ERR);
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERR);
    end
  end

  assign isCount            = is_count_q;
  assign isRead             = is_read_q;
  assign continuePcnt       = cont_pcnt_q;
  assign continueAcc        = cont_acc_q;
  assign addPcnts           = cont_acc_q;
  assign binarizeStart      = bin_start_q;
  assign out_valid          = out_valid_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;
  assign firstInputAddress  = ia_q;
  assign firstWeightAddress = wa_q;
  assign pix_index          = pix_q;

endmodule
